// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX/MEM pipeline register with CCR, interrupt shadow and IN/OUT ports
module ex_mem_stage #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int OP_W   = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [2:0]        alu_flag,
    input  logic [OP_W-1:0]   alu_operation,
    input  logic [DATA_W-1:0] store_data,
    input  logic [REG_AW-1:0] rdst,
    input  logic              reg_write,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              setc,
    input  logic              clrc,
    input  logic              int_save,
    input  logic              rti_restore,
    input  logic [DATA_W-1:0] in_port,
    output logic              mem_valid,
    output logic [DATA_W-1:0] mem_result,
    output logic [DATA_W-1:0] mem_store_data,
    output logic [REG_AW-1:0] mem_rdst,
    output logic              mem_reg_write,
    output logic              mem_mem_read,
    output logic              mem_mem_write,
    output logic [2:0]        ccr,
    output logic [DATA_W-1:0] out_port
);

    // Opcodes that update Z/N and those that additionally update C
    localparam logic [OP_W-1:0] ZN_OPS = OP_W'(13'h03BF);
    localparam logic [OP_W-1:0] C_OPS  = OP_W'(13'h0123);
    localparam int OP_IN  = 11;
    localparam int OP_OUT = 12;

    logic [2:0] shadow;
    logic [2:0] ccr_next;
    logic [2:0] shadow_next;

    always_comb begin
        ccr_next = ccr;
        if (in_valid && |(alu_operation & ZN_OPS)) begin
            ccr_next[0] = (alu_result == '0);
            ccr_next[1] = alu_result[DATA_W-1];
        end
        if (in_valid && |(alu_operation & C_OPS))
            ccr_next[2] = alu_flag[2];
        if (setc)
            ccr_next[2] = 1'b1;
        if (clrc)
            ccr_next[2] = 1'b0;
        if (rti_restore)
            ccr_next = shadow;
        shadow_next = int_save ? ccr_next : shadow;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_valid      <= 1'b0;
            mem_result     <= '0;
            mem_store_data <= '0;
            mem_rdst       <= '0;
            mem_reg_write  <= 1'b0;
            mem_mem_read   <= 1'b0;
            mem_mem_write  <= 1'b0;
            ccr            <= '0;
            shadow         <= '0;
            out_port       <= '0;
        end else if (stall) begin
            // MEM not ready: everything holds
        end else if (flush) begin
            mem_valid     <= 1'b0;
            mem_reg_write <= 1'b0;
            mem_mem_read  <= 1'b0;
            mem_mem_write <= 1'b0;
        end else begin
            mem_valid      <= in_valid;
            mem_result     <= alu_operation[OP_IN] ? in_port : alu_result;
            mem_store_data <= store_data;
            mem_rdst       <= rdst;
            mem_reg_write  <= reg_write & in_valid;
            mem_mem_read   <= mem_read & in_valid;
            mem_mem_write  <= mem_write & in_valid;
            ccr            <= ccr_next;
            shadow         <= shadow_next;
            if (in_valid && alu_operation[OP_OUT])
                out_port <= store_data;
        end
    end

endmodule
